apb3_master_arbiter: RTL and testbench

//  Shares one APB3 master port between NUM_REQ on-chip requesters (e.g. MSS FIC and fabric DMA).

---
 rtl/apb3_master_arbiter_if.sv | 37 +++
 rtl/apb3_master_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_apb3_master_arbiter.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/apb3_master_arbiter_if.sv
// Signal bundle between apb3_master_arbiter, its requesters and the APB3
// slave-side decoder/mux.
//   master : the arbiter's view (drives the APB3 master signals and responses)
//   slave  : the environment's view (requesters plus slave-side mux)
interface apb3_master_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32
);
  // requester side
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*32-1:0]         req_wdata;
  logic [NUM_REQ-1:0]            done;
  logic [31:0]                   rsp_rdata;
  logic                          rsp_err;
  logic                          busy;
  // APB3 side
  logic [ADDR_WIDTH-1:0]         paddr;
  logic                          psel;
  logic                          penable;
  logic                          pwrite;
  logic [31:0]                   pwdata;
  logic [31:0]                   prdata;
  logic                          pready;
  logic                          pslverr;

  modport master (
    input  req, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output done, rsp_rdata, rsp_err, busy, paddr, psel, penable, pwrite, pwdata
  );

  modport slave (
    output req, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  done, rsp_rdata, rsp_err, busy, paddr, psel, penable, pwrite, pwdata
  );
endinterface

// File: rtl/apb3_master_arbiter.sv
// apb3_master_arbiter: shares one APB3 master port between NUM_REQ requesters
// with round-robin arbitration and a single transfer in flight.
// Optional feature macro: APB_TIMEOUT_EN (ACCESS wait-state limit of
// TIMEOUT_CYCLES, aborting with RSP_ERR=1 and RSP_RDATA=0).
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | no transfer; arbitrate among REQ and latch the winner
//  S_SETUP  | APB3 setup phase (PSEL=1, PENABLE=0), always one cycle
//  S_ACCESS | APB3 access phase (PSEL=PENABLE=1), waits for PREADY
//  S_DONE   | DONE pulse to the granted requester, no arbitration
module apb3_master_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic                   i_pclk,
  input logic                   i_presetn,
  apb3_master_arbiter_if.master io_bus
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                r_state,   w_state_nxt;
  logic [PW-1:0]         r_ptr,     w_ptr_nxt;
  logic [PW-1:0]         r_gnt,     w_gnt_nxt;
  logic [ADDR_WIDTH-1:0] r_paddr,   w_paddr_nxt;
  logic                  r_psel,    w_psel_nxt;
  logic                  r_penable, w_penable_nxt;
  logic                  r_pwrite,  w_pwrite_nxt;
  logic [31:0]           r_pwdata,  w_pwdata_nxt;
  logic [31:0]           r_rdata,   w_rdata_nxt;
  logic                  r_err,     w_err_nxt;
  logic [NUM_REQ-1:0]    r_done,    w_done_nxt;
  logic                  r_busy,    w_busy_nxt;

  logic [PW-1:0]         w_pick;
  logic [NUM_REQ-1:0]    w_wr_sh;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [31:0]           w_sel_wdata;
  logic                  w_sel_write;

`ifdef APB_TIMEOUT_EN
  logic [15:0]           r_wait_cnt, w_wait_cnt_nxt;
`else
  logic                  w_unused_timeout_cfg;
  // The wait limit has no meaning without the timeout counter.
  assign w_unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // First set request found searching upward (wrapping) from ptr+1.
  function automatic logic [PW-1:0] f_rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [PW-1:0]      ptr);
    logic [PW-1:0]      pick;
    logic               found;
    logic [NUM_REQ-1:0] sh;
    int                 idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      sh  = req >> idx;
      if (!found && sh[0]) begin
        found = 1'b1;
        pick  = PW'(idx);
      end
    end
    return pick;
  endfunction

  // Winner of the current request vector and its transfer attributes.
  always_comb begin
    w_pick      = f_rr_pick(io_bus.req, r_ptr);
    w_wr_sh     = io_bus.req_write >> w_pick;
    w_sel_write = w_wr_sh[0];
    w_sel_addr  = ADDR_WIDTH'(io_bus.req_addr >> (int'(w_pick) * ADDR_WIDTH));
    w_sel_wdata = 32'(io_bus.req_wdata >> (int'(w_pick) * 32));
  end

  // Next-state and next-output decode; every output is a register.
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_gnt_nxt     = r_gnt;
    w_paddr_nxt   = r_paddr;
    w_psel_nxt    = r_psel;
    w_penable_nxt = r_penable;
    w_pwrite_nxt  = r_pwrite;
    w_pwdata_nxt  = r_pwdata;
    w_rdata_nxt   = r_rdata;
    w_err_nxt     = r_err;
    w_done_nxt    = '0;
    w_busy_nxt    = r_busy;
`ifdef APB_TIMEOUT_EN
    w_wait_cnt_nxt = r_wait_cnt;
`endif
    case (r_state)
      S_IDLE: begin
        if (|io_bus.req) begin
          w_gnt_nxt    = w_pick;
          w_paddr_nxt  = w_sel_addr;
          w_pwrite_nxt = w_sel_write;
          w_pwdata_nxt = w_sel_wdata;
          w_psel_nxt   = 1'b1;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = S_SETUP;
`ifdef APB_TIMEOUT_EN
          w_wait_cnt_nxt = '0;
`endif
        end
      end
      S_SETUP: begin
        w_penable_nxt = 1'b1;
        w_state_nxt   = S_ACCESS;
      end
      S_ACCESS: begin
        if (io_bus.pready) begin
          if (!r_pwrite) begin
            w_rdata_nxt = io_bus.prdata;
          end
          w_err_nxt     = io_bus.pslverr;
          w_done_nxt    = NUM_REQ'(1) << r_gnt;
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          w_ptr_nxt     = r_gnt;
          w_state_nxt   = S_DONE;
        end
`ifdef APB_TIMEOUT_EN
        // This is the TIMEOUT_CYCLES-th stalled ACCESS cycle: give up.
        else if (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
          w_rdata_nxt   = 32'h0;
          w_err_nxt     = 1'b1;
          w_done_nxt    = NUM_REQ'(1) << r_gnt;
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          w_ptr_nxt     = r_gnt;
          w_state_nxt   = S_DONE;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 16'd1;
        end
`endif
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_pclk) begin
    if (!i_presetn) begin
      r_state   <= S_IDLE;
      r_ptr     <= PW'(NUM_REQ - 1);
      r_gnt     <= '0;
      r_paddr   <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_done    <= '0;
      r_busy    <= 1'b0;
`ifdef APB_TIMEOUT_EN
      r_wait_cnt <= '0;
`endif
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_gnt     <= w_gnt_nxt;
      r_paddr   <= w_paddr_nxt;
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
      r_pwrite  <= w_pwrite_nxt;
      r_pwdata  <= w_pwdata_nxt;
      r_rdata   <= w_rdata_nxt;
      r_err     <= w_err_nxt;
      r_done    <= w_done_nxt;
      r_busy    <= w_busy_nxt;
`ifdef APB_TIMEOUT_EN
      r_wait_cnt <= w_wait_cnt_nxt;
`endif
    end
  end

  assign io_bus.paddr     = r_paddr;
  assign io_bus.psel      = r_psel;
  assign io_bus.penable   = r_penable;
  assign io_bus.pwrite    = r_pwrite;
  assign io_bus.pwdata    = r_pwdata;
  assign io_bus.rsp_rdata = r_rdata;
  assign io_bus.rsp_err   = r_err;
  assign io_bus.done      = r_done;
  assign io_bus.busy      = r_busy;

endmodule

// File: tb/tb_apb3_master_arbiter.sv
// Bench for apb3_master_arbiter: directed scenarios plus randomized transfers
// checked against a transaction-level round-robin / response model.
module tb_apb3_master_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 32;
  localparam int TO   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  apb3_master_arbiter_if #(.NUM_REQ(NREQ), .ADDR_WIDTH(AW)) bus ();

  apb3_master_arbiter #(
    .NUM_REQ(NREQ), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_pclk   (clk),
    .i_presetn(rst_n),
    .io_bus   (bus)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          m_ptr;
  logic [31:0] m_rdata;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester after the last granted one.
  function automatic int model_pick(input logic [NREQ-1:0] mask);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (m_ptr + k) % NREQ;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic rand_fill();
    for (int r = 0; r < NREQ; r++) begin
      bus.req_write[r]          = 1'($urandom);
      bus.req_addr[r*AW +: AW]  = $urandom;
      bus.req_wdata[r*32 +: 32] = $urandom;
    end
  endtask

  // One complete transfer starting from an IDLE negedge; nwait stalled
  // ACCESS cycles precede PREADY.
  task automatic do_xfer(input logic [NREQ-1:0] mask, input int nwait,
                         input logic slverr, input logic [31:0] rd, output int g);
    int          nw_eff;
    int          stall_bad;
    bit          abort;
    logic [AW-1:0] e_addr;
    logic        e_wr;
    logic [31:0] e_wd;
    g         = model_pick(mask);
    e_addr    = bus.req_addr[g*AW +: AW];
    e_wr      = bus.req_write[g];
    e_wd      = bus.req_wdata[g*32 +: 32];
    abort     = 1'b0;
    nw_eff    = nwait;
    stall_bad = 0;
`ifdef APB_TIMEOUT_EN
    if (nwait >= TO) begin
      abort  = 1'b1;
      nw_eff = TO - 1;
    end
`endif
    bus.req     = mask;
    bus.pready  = 1'b0;
    bus.pslverr = 1'($urandom);
    bus.prdata  = $urandom;
    @(negedge clk);
    check_val("setup_sel_en", {bus.psel, bus.penable, bus.busy}, 3'b101);
    check_val("setup_paddr",  bus.paddr, e_addr);
    check_val("setup_pwrite", bus.pwrite, e_wr);
    check_val("setup_pwdata", bus.pwdata, e_wd);
    check_val("setup_done",   bus.done, 0);
    @(negedge clk);
    check_val("access_sel_en", {bus.psel, bus.penable}, 2'b11);
    for (int w = 0; w < nw_eff; w++) begin
      bus.pready  = 1'b0;
      bus.prdata  = $urandom;
      bus.pslverr = 1'($urandom);
      bus.req_addr[(1-g)*AW +: AW]  = $urandom;
      bus.req_wdata[(1-g)*32 +: 32] = $urandom;
      @(negedge clk);
      if (!(bus.psel === 1'b1 && bus.penable === 1'b1) || bus.done !== '0 ||
          bus.paddr !== e_addr || bus.pwdata !== e_wd || bus.pwrite !== e_wr)
        stall_bad++;
    end
    if (nw_eff > 0) check_val("stall_stable", stall_bad, 0);
    bus.pready  = !abort;
    bus.prdata  = rd;
    bus.pslverr = slverr;
    @(negedge clk);
    if (abort) m_rdata = 32'h0;
    else if (!e_wr) m_rdata = rd;
    check_val("done_pulse", bus.done, (1 << g));
    check_val("rsp_err",    bus.rsp_err, abort ? 1'b1 : slverr);
    check_val("rsp_rdata",  bus.rsp_rdata, m_rdata);
    check_val("done_bus",   {bus.psel, bus.penable, bus.busy}, 3'b001);
    m_ptr      = g;
    bus.req[g] = 1'b0;
    bus.pready = 1'b0;
    @(negedge clk);
    check_val("after_done", {bus.done, bus.psel, bus.busy}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int g, prev_g;
    bus.req       = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;

    // reset with both requesters asserted
    rst_n   = 1'b0;
    bus.req = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_psel",    bus.psel, 0);
    check_val("rst_penable", bus.penable, 0);
    check_val("rst_done",    bus.done, 0);
    check_val("rst_busy",    bus.busy, 0);
    check_val("rst_rdata",   bus.rsp_rdata, 0);
    check_val("rst_err",     bus.rsp_err, 0);
    check_val("rst_paddr",   bus.paddr, 0);
    check_val("rst_pwdata",  {bus.pwrite, bus.pwdata}, 0);
    m_ptr   = NREQ - 1;
    m_rdata = 32'h0;

    // first grant after reset goes to requester 0: zero-wait read
    bus.req_addr  = {32'h4000_0200, 32'h4000_0010};
    bus.req_write = 2'b00;
    rst_n = 1'b1;
    do_xfer(2'b11, 0, 1'b0, 32'hA5A5_1234, g);
    check_val("t2_grant0", g, 0);
    check_val("t2_rdata",  bus.rsp_rdata, 32'hA5A5_1234);

    // write with 3 wait states and slave error
    bus.req_write[1]       = 1'b1;
    bus.req_addr[63:32]    = 32'h4000_0100;
    bus.req_wdata[63:32]   = 32'hCAFE_0001;
    do_xfer(2'b10, 3, 1'b1, 32'h1111_2222, g);
    check_val("t3_rdata_kept", bus.rsp_rdata, 32'hA5A5_1234);
    check_val("t3_err",        bus.rsp_err, 1);

    // fairness with both requesting every time
    prev_g = g;
    for (int i = 0; i < 8; i++) begin
      rand_fill();
      do_xfer(2'b11, $urandom_range(0, 2), 1'($urandom), $urandom, g);
      check_val("t4_alternate", g, 1 - prev_g);
      prev_g = g;
    end

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      rand_fill();
      do_xfer(NREQ'($urandom_range(1, 3)), $urandom_range(0, 4), 1'($urandom), $urandom, g);
    end

    // reset in the middle of ACCESS: pointer must return to NREQ-1
    rand_fill();
    do_xfer(2'b01, 0, 1'b0, $urandom, g);
    bus.req    = 2'b10;
    bus.pready = 1'b0;
    repeat (3) @(negedge clk);
    check_val("t5_pre_access", {bus.psel, bus.penable}, 2'b11);
    rst_n = 1'b0;
    @(negedge clk);
    check_val("t5_sel_en", {bus.psel, bus.penable}, 0);
    check_val("t5_done",   bus.done, 0);
    check_val("t5_rsp",    {bus.busy, bus.rsp_err, bus.rsp_rdata}, 0);
    rst_n      = 1'b1;
    bus.req    = 2'b00;
    bus.pready = 1'b1;
    m_ptr      = NREQ - 1;
    m_rdata    = 32'h0;
    @(negedge clk);
    check_val("t5_no_done", {bus.done, bus.psel}, 0);
    bus.pready = 1'b0;
    rand_fill();
    do_xfer(2'b11, 1, 1'b0, $urandom, g);
    check_val("t5_ptr_reset", g, 0);

    // stuck PREADY
    rand_fill();
    bus.req_write[0] = 1'b0;
`ifdef APB_TIMEOUT_EN
    do_xfer(2'b01, TO, 1'b0, 32'hDEAD_BEEF, g);
    check_val("t6_abort_rdata", bus.rsp_rdata, 32'h0);
    check_val("t6_abort_err",   bus.rsp_err, 1);
    rand_fill();
    bus.req_write[1] = 1'b0;
    do_xfer(2'b10, TO - 1, 1'b0, 32'h0BAD_F00D, g);
    check_val("t6_limit_ready_wins", bus.rsp_err, 0);
`else
    do_xfer(2'b01, 1100, 1'b0, 32'h600D_CAFE, g);
    check_val("t6_long_wait_rdata", bus.rsp_rdata, 32'h600D_CAFE);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
